llc_req_arbiter: RTL

- Sits between the trace/L1 front end and the LLC.
- Buffers processor-side requests (ops 0,1,2,8,9) and snooped-bus requests (ops 3,4,5,6) in two small FIFOs.
- Picks one request per slot and issues it to the LLC as a single-cycle command, honouring the LLC's hold back-pressure.
- Orders clear (8) and print (9) as barriers behind all outstanding snoops.

---
 rtl/llc_req_arbiter_pkg.sv | 50 +++++
 rtl/llc_req_arbiter_fifo.sv | 68 ++++++
 rtl/llc_req_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/llc_req_arbiter_pkg.sv
// ============================================================================
// Module   : llc_req_arbiter_pkg
// Brief    : Shared op codes, request record and arbiter state encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package llc_req_arbiter_pkg;

  localparam int c_llc_addr_w = 32;

  typedef enum logic [3:0] {
    READ_D   = 4'd0,
    WRITE_D  = 4'd1,
    READ_I   = 4'd2,
    SNP_INV  = 4'd3,
    SNP_RD   = 4'd4,
    SNP_WR   = 4'd5,
    SNP_RWIM = 4'd6,
    CLR      = 4'd8,
    PRINT    = 4'd9,
    NOP      = 4'hF
  } llc_op_e;

  typedef struct packed {
    llc_op_e                 op;
    logic [c_llc_addr_w-1:0] addr;
  } llc_req_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

  function automatic logic is_cpu_op(input logic [3:0] op);
    return (op inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9});
  endfunction

  function automatic logic is_snp_op(input logic [3:0] op);
    return (op inside {[4'd3:4'd6]});
  endfunction

  function automatic logic is_barrier(input llc_op_e op);
    return (op == CLR) || (op == PRINT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/llc_req_arbiter_fifo.sv
// ============================================================================
// Module   : llc_req_fifo
// Brief    : Synchronous request FIFO with registered full/empty flags
// Revision : 1.0
// ============================================================================
`default_nettype none

module llc_req_fifo
  import llc_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  llc_req_t i_din,
  input  logic     i_pop,
  output llc_req_t o_dout,
  output logic     o_full,
  output logic     o_empty
);

  localparam int c_ptr_w = $clog2(DEPTH);

  llc_req_t           r_mem [DEPTH];
  logic [c_ptr_w:0]   r_wr_ptr;
  logic [c_ptr_w:0]   r_rd_ptr;
  logic               r_full;
  logic               r_empty;
  logic               w_push_ok;
  logic               w_pop_ok;
  logic [c_ptr_w:0]   w_wr_nxt;
  logic [c_ptr_w:0]   w_rd_nxt;

  assign w_push_ok = i_push && !r_full;
  assign w_pop_ok  = i_pop && !r_empty;
  assign w_wr_nxt  = r_wr_ptr + (c_ptr_w+1)'(w_push_ok);
  assign w_rd_nxt  = r_rd_ptr + (c_ptr_w+1)'(w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[c_ptr_w-1:0]] <= i_din;
    end
  end

  // Flags come from the next pointers so they are valid straight off the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_empty  <= (w_wr_nxt == w_rd_nxt);
      r_full   <= (w_wr_nxt[c_ptr_w] != w_rd_nxt[c_ptr_w]) &&
                  (w_wr_nxt[c_ptr_w-1:0] == w_rd_nxt[c_ptr_w-1:0]);
    end
  end

  assign o_dout  = r_mem[r_rd_ptr[c_ptr_w-1:0]];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

`default_nettype wire

// File: rtl/llc_req_arbiter.sv
// ============================================================================
// Module   : llc_req_arbiter
// Brief    : CPU/snoop request arbiter feeding single-cycle LLC commands.
//            Optional statistics outputs enabled by LLC_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module llc_req_arbiter
  import llc_req_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_SNP_BURST = 3,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [3:0]        cpu_op,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  logic [3:0]        snp_op,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              llc_valid,
  output logic [3:0]        llc_op,
  output logic [ADDR_W-1:0] llc_addr,
  input  logic              llc_hold,
  output logic              err_illegal
`ifdef LLC_ARB_STATS_EN
  ,
  output logic [31:0]       stat_cpu_issued,
  output logic [31:0]       stat_snp_issued,
  output logic [31:0]       stat_hold_cycles
`endif
);

  localparam int                 c_burst_w   = $clog2(MAX_SNP_BURST + 1);
  localparam logic [c_burst_w-1:0] c_burst_max = c_burst_w'(MAX_SNP_BURST);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic                r_llc_valid;
  llc_op_e             r_llc_op;
  logic [ADDR_W-1:0]   r_llc_addr;
  logic                r_err;
  logic [c_burst_w-1:0] r_burst;

  logic                w_valid_nxt;
  llc_op_e             w_op_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_grant;

  llc_req_t            w_cpu_din;
  llc_req_t            w_snp_din;
  llc_req_t            w_cpu_head;
  llc_req_t            w_snp_head;
  llc_req_t            w_sel;
  logic                w_cpu_full;
  logic                w_cpu_empty;
  logic                w_snp_full;
  logic                w_snp_empty;
  logic                w_cpu_xfer;
  logic                w_snp_xfer;
  logic                w_cpu_legal;
  logic                w_snp_legal;
  logic                w_cpu_elig;
  logic                w_snp_elig;
  logic                w_cand;
  logic                w_pick_cpu;
  logic                w_pop_cpu;
  logic                w_pop_snp;

  assign cpu_ready   = !w_cpu_full;
  assign snp_ready   = !w_snp_full;
  assign w_cpu_xfer  = cpu_valid && cpu_ready;
  assign w_snp_xfer  = snp_valid && snp_ready;
  assign w_cpu_legal = is_cpu_op(cpu_op);
  assign w_snp_legal = is_snp_op(snp_op);

  assign w_cpu_din = '{op: llc_op_e'(cpu_op), addr: c_llc_addr_w'(cpu_addr)};
  assign w_snp_din = '{op: llc_op_e'(snp_op), addr: c_llc_addr_w'(snp_addr)};

  llc_req_fifo #(.DEPTH(FIFO_DEPTH)) u_cpu_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_cpu_xfer && w_cpu_legal),
    .i_din   (w_cpu_din),
    .i_pop   (w_pop_cpu),
    .o_dout  (w_cpu_head),
    .o_full  (w_cpu_full),
    .o_empty (w_cpu_empty)
  );

  llc_req_fifo #(.DEPTH(FIFO_DEPTH)) u_snp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_snp_xfer && w_snp_legal),
    .i_din   (w_snp_din),
    .i_pop   (w_pop_snp),
    .o_dout  (w_snp_head),
    .o_full  (w_snp_full),
    .o_empty (w_snp_empty)
  );

  // Clear/print wait until every queued snoop has been issued.
  assign w_snp_elig = !w_snp_empty;
  assign w_cpu_elig = !w_cpu_empty && (!is_barrier(w_cpu_head.op) || w_snp_empty);
  assign w_cand     = w_cpu_elig || w_snp_elig;
  assign w_pick_cpu = w_cpu_elig && (!w_snp_elig || (r_burst == c_burst_max));
  assign w_sel      = w_pick_cpu ? w_cpu_head : w_snp_head;
  assign w_pop_cpu  = w_grant && w_pick_cpu;
  assign w_pop_snp  = w_grant && !w_pick_cpu;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_valid_nxt = 1'b0;
    w_op_nxt    = NOP;
    w_addr_nxt  = r_llc_addr;
    case (r_state)
      ARB: begin
        if (w_cand) begin
          w_grant     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (llc_hold) begin
          w_state_nxt = HOLD;
        end else if (w_cand) begin
          w_grant     = 1'b1;
        end else begin
          w_state_nxt = ARB;
        end
      end
      HOLD: begin
        if (!llc_hold) begin
          w_state_nxt = ARB;
        end
      end
      default: w_state_nxt = ARB;
    endcase
    if (w_grant) begin
      w_valid_nxt = 1'b1;
      w_op_nxt    = w_sel.op;
      w_addr_nxt  = w_sel.addr[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB;
      r_llc_valid <= 1'b0;
      r_llc_op    <= NOP;
      r_llc_addr  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_llc_valid <= w_valid_nxt;
      r_llc_op    <= w_op_nxt;
      r_llc_addr  <= w_addr_nxt;
      r_err       <= (w_cpu_xfer && !w_cpu_legal) || (w_snp_xfer && !w_snp_legal);
    end
  end

  // Consecutive snoop grants counted only while a CPU request is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst <= '0;
    end else if (w_cpu_empty || w_pop_cpu) begin
      r_burst <= '0;
    end else if (w_pop_snp && (r_burst != c_burst_max)) begin
      r_burst <= r_burst + c_burst_w'(1);
    end
  end

  assign llc_valid   = r_llc_valid;
  assign llc_op      = r_llc_op;
  assign llc_addr    = r_llc_addr;
  assign err_illegal = r_err;

`ifdef LLC_ARB_STATS_EN
  logic [31:0] r_stat_cpu;
  logic [31:0] r_stat_snp;
  logic [31:0] r_stat_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_cpu  <= '0;
      r_stat_snp  <= '0;
      r_stat_hold <= '0;
    end else begin
      if (w_pop_cpu && (r_stat_cpu != '1)) r_stat_cpu <= r_stat_cpu + 32'd1;
      if (w_pop_snp && (r_stat_snp != '1)) r_stat_snp <= r_stat_snp + 32'd1;
      if ((r_state == HOLD) && (r_stat_hold != '1)) r_stat_hold <= r_stat_hold + 32'd1;
    end
  end

  assign stat_cpu_issued  = r_stat_cpu;
  assign stat_snp_issued  = r_stat_snp;
  assign stat_hold_cycles = r_stat_hold;
`endif

endmodule

`default_nettype wire
